// File: rtl/aidan_mcnay_prime_seq.sv
// Purpose : trial-division primality sequencer driving one remainder divider.
// Latency : n<2 -> 1 cycle; n=2/3 -> 2 cycles; else ~(CHECK+REQ+WAIT+divider) per trial.
// Backpressure: one request outstanding at a time; verdict held on out_val until out_rdy.
//
// Ports:
//   clk, reset (async, active-low)
//   in_num/in_val/in_rdy           candidate stream
//   div_opa/div_opb/div_req_val/div_req_rdy     divider request (n, trial d)
//   div_result/div_resp_val/div_resp_rdy        divider remainder response
//   is_prime/factor/out_val/out_rdy             verdict stream (factor=0 if prime or n<2)
// Build option: define PRIME_SEQ_ODD_ONLY_EN to skip even trial divisors above 2.
module aidan_mcnay_prime_seq #(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] in_num,
  input  logic             in_val,
  output logic             in_rdy,
  output logic [nbits-1:0] div_opa,
  output logic [nbits-1:0] div_opb,
  output logic             div_req_val,
  input  logic             div_req_rdy,
  input  logic [nbits-1:0] div_result,
  input  logic             div_resp_val,
  output logic             div_resp_rdy,
  output logic             is_prime,
  output logic [nbits-1:0] factor,
  output logic             out_val,
  input  logic             out_rdy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [nbits-1:0] n_q, n_d;
  logic [nbits-1:0] d_q, d_d;
  logic [nbits-1:0] factor_q, factor_d;
  logic             is_prime_q, is_prime_d;

  // Square at double width so d*d never wraps for any d.
  logic [2*nbits-1:0] d_sq;
  logic [2*nbits-1:0] n_ext;
  logic [nbits-1:0]   d_next;

  assign n_ext = {{nbits{1'b0}}, n_q};
  assign d_sq  = {{nbits{1'b0}}, d_q} * {{nbits{1'b0}}, d_q};

`ifdef PRIME_SEQ_ODD_ONLY_EN
  // 2 is the only even divisor worth trying; afterwards step through odd values.
  assign d_next = (d_q == nbits'(2)) ? nbits'(3) : d_q + nbits'(2);
`else
  assign d_next = d_q + nbits'(1);
`endif

  assign div_opa  = n_q;
  assign div_opb  = d_q;
  assign is_prime = is_prime_q;
  assign factor   = factor_q;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    d_d          = d_q;
    factor_d     = factor_q;
    is_prime_d   = is_prime_q;
    in_rdy       = 1'b0;
    div_req_val  = 1'b0;
    div_resp_rdy = 1'b0;
    out_val      = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by reset so nothing is advertised while held in reset.
        in_rdy = reset;
        if (in_val) begin
          n_d = in_num;
          d_d = nbits'(2);
          if (in_num < nbits'(2)) begin
            is_prime_d = 1'b0;
            factor_d   = '0;
            state_d    = DONE;
          end else begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (d_sq > n_ext) begin
          is_prime_d = 1'b1;
          factor_d   = '0;
          state_d    = DONE;
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        div_req_val = 1'b1;
        if (div_req_rdy) state_d = WAIT;
      end
      WAIT: begin
        div_resp_rdy = 1'b1;
        if (div_resp_val) begin
          if (div_result == '0) begin
            is_prime_d = 1'b0;
            factor_d   = d_q;
            state_d    = DONE;
          end else begin
            d_d     = d_next;
            state_d = CHECK;
          end
        end
      end
      DONE: begin
        out_val = 1'b1;
        if (out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      d_q        <= '0;
      factor_q   <= '0;
      is_prime_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      d_q        <= d_d;
      factor_q   <= factor_d;
      is_prime_q <= is_prime_d;
    end
  end

endmodule

// File: tb/tb_aidan_mcnay_prime_seq.sv
module tb_aidan_mcnay_prime_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_num = '0;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [15:0] div_opa, div_opb;
  logic        div_req_val;
  logic        div_req_rdy = 1'b0;
  logic [15:0] div_result = '0;
  logic        div_resp_val = 1'b0;
  logic        div_resp_rdy;
  logic        is_prime;
  logic [15:0] factor;
  logic        out_val;
  logic        out_rdy = 1'b1;

  always #5 clk = ~clk;

  aidan_mcnay_prime_seq #(.nbits(16)) dut (
    .clk(clk), .reset(reset),
    .in_num(in_num), .in_val(in_val), .in_rdy(in_rdy),
    .div_opa(div_opa), .div_opb(div_opb),
    .div_req_val(div_req_val), .div_req_rdy(div_req_rdy),
    .div_result(div_result), .div_resp_val(div_resp_val), .div_resp_rdy(div_resp_rdy),
    .is_prime(is_prime), .factor(factor), .out_val(out_val), .out_rdy(out_rdy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick(input int def_cnt, input int odd_cnt);
`ifdef PRIME_SEQ_ODD_ONLY_EN
    return odd_cnt;
`else
    return def_cnt;
`endif
  endfunction

  // Behavioural divider: optional random handshake delays, computes n mod d.
  logic        rand_en = 1'b0;
  logic        hold_rsp = 1'b0;
  logic        busy = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_opb = '0;
  logic [15:0] m_rem = '0;
  int          rdy_wait = 0;
  int          rsp_wait = 0;
  int          req_cnt = 0;
  int          opb_unstable = 0;
  int          proto_err = 0;
  logic [15:0] req_log[$];

  always @(negedge clk or negedge reset) begin
    div_resp_val = 1'b0;
    div_req_rdy  = 1'b0;
    if (!reset) begin
      busy       = 1'b0;
      prev_stall = 1'b0;
      rdy_wait   = 0;
      rsp_wait   = 0;
    end else begin
      if (prev_stall && div_req_val && (div_opb !== prev_opb)) opb_unstable++;
      prev_stall = 1'b0;
      if (div_req_val) begin
        if (busy) proto_err++;
        if (rdy_wait > 0) begin
          rdy_wait--;
          prev_stall = 1'b1;
          prev_opb   = div_opb;
        end else begin
          div_req_rdy = 1'b1;
          req_cnt++;
          req_log.push_back(div_opb);
          m_rem    = (div_opb == 16'd0) ? 16'hFFFF : div_opa % div_opb;
          busy     = 1'b1;
          rsp_wait = rand_en ? int'($urandom_range(0, 3)) : 0;
          rdy_wait = rand_en ? int'($urandom_range(0, 3)) : 0;
        end
      end else if (busy && div_resp_rdy && !hold_rsp) begin
        if (rsp_wait > 0) rsp_wait--;
        else begin
          div_resp_val = 1'b1;
          div_result   = m_rem;
          busy         = 1'b0;
        end
      end
    end
  end

  // Offer one candidate, wait for the verdict, optionally stall the consumer.
  task automatic run_cand(input logic [15:0] n, input int stall,
                          output logic p, output logic [15:0] f,
                          output int reqs, output int lat, output int held_bad);
    int t;
    held_bad = 0;
    @(negedge clk);
    out_rdy = (stall == 0);
    in_num  = n;
    in_val  = 1'b1;
    t = 0;
    while (!in_rdy && t < 50) begin @(negedge clk); t++; end
    req_cnt = 0;
    req_log.delete();
    @(posedge clk);
    @(negedge clk);
    in_val = 1'b0;
    lat = 1;
    while (!out_val && lat < 20000) begin @(negedge clk); lat++; end
    chk($sformatf("verdict_arrives n=%0d", n), int'(out_val), 1);
    p    = is_prime;
    f    = factor;
    reqs = req_cnt;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!out_val || is_prime !== p || factor !== f) held_bad++;
    end
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("in_rdy_after_done n=%0d", n), int'(in_rdy), 1);
  endtask

  typedef struct {
    logic [15:0] n;
    logic        exp_prime;
    logic [15:0] exp_factor;
    int          reqs_def;
    int          reqs_odd;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic        p;
    logic [15:0] f;
    int          reqs, lat, held_bad, t;

    vecs[0]  = '{16'd0,     1'b0, 16'd0,  0,  0};
    vecs[1]  = '{16'd1,     1'b0, 16'd0,  0,  0};
    vecs[2]  = '{16'd2,     1'b1, 16'd0,  0,  0};
    vecs[3]  = '{16'd3,     1'b1, 16'd0,  0,  0};
    vecs[4]  = '{16'd4,     1'b0, 16'd2,  1,  1};
    vecs[5]  = '{16'd5,     1'b1, 16'd0,  1,  1};
    vecs[6]  = '{16'd9,     1'b0, 16'd3,  2,  2};
    vecs[7]  = '{16'd15,    1'b0, 16'd3,  2,  2};
    vecs[8]  = '{16'd25,    1'b0, 16'd5,  4,  3};
    vecs[9]  = '{16'd49,    1'b0, 16'd7,  6,  4};
    vecs[10] = '{16'd97,    1'b1, 16'd0,  8,  5};
    vecs[11] = '{16'd143,   1'b0, 16'd11, 10, 6};
    vecs[12] = '{16'd65535, 1'b0, 16'd3,  2,  2};

    // Reset held with a candidate waiting: nothing may be accepted or issued.
    reset  = 1'b0;
    in_val = 1'b1;
    in_num = 16'd7;
    repeat (4) @(negedge clk);
    chk("rst_in_rdy", int'(in_rdy), 0);
    chk("rst_out_val", int'(out_val), 0);
    chk("rst_div_req_val", int'(div_req_val), 0);
    chk("rst_no_requests", req_cnt, 0);
    reset  = 1'b1;
    in_val = 1'b0;
    #1;
    chk("post_rst_in_rdy", int'(in_rdy), 1);
    chk("post_rst_is_prime", int'(is_prime), 0);
    chk("post_rst_factor", int'(factor), 0);
    chk("post_rst_resp_rdy", int'(div_resp_rdy), 0);

    foreach (vecs[i]) begin
      run_cand(vecs[i].n, 0, p, f, reqs, lat, held_bad);
      chk($sformatf("is_prime n=%0d", vecs[i].n), int'(p), int'(vecs[i].exp_prime));
      chk($sformatf("factor n=%0d", vecs[i].n), int'(f), int'(vecs[i].exp_factor));
      chk($sformatf("requests n=%0d", vecs[i].n), reqs, pick(vecs[i].reqs_def, vecs[i].reqs_odd));
      if (vecs[i].n < 16'd2) chk($sformatf("latency n=%0d", vecs[i].n), lat, 1);
      if (vecs[i].n == 16'd2 || vecs[i].n == 16'd3) chk($sformatf("latency n=%0d", vecs[i].n), lat, 2);
      if (vecs[i].n == 16'd9 && req_log.size() == 2) begin
        chk("n9_first_divisor", int'(req_log[0]), 2);
        chk("n9_second_divisor", int'(req_log[1]), 3);
      end
      if (vecs[i].n == 16'd49 && req_log.size() >= 3) begin
        chk("n49_last_divisor", int'(req_log[req_log.size()-1]), 7);
        chk("n49_third_divisor", int'(req_log[2]), pick(4, 5));
      end
    end

    // Largest 16-bit prime with random divider delays and a stalled consumer.
    rand_en = 1'b1;
    run_cand(16'd65521, 5, p, f, reqs, lat, held_bad);
    rand_en = 1'b0;
    chk("big_is_prime", int'(p), 1);
    chk("big_factor", int'(f), 0);
    chk("big_requests", reqs, pick(254, 128));
    chk("big_held_during_stall", held_bad, 0);
    chk("big_opb_stable", opb_unstable, 0);
    chk("one_outstanding_request", proto_err, 0);

    // Reset while waiting on the divider, then rerun the same candidate.
    hold_rsp = 1'b1;
    @(negedge clk);
    in_num = 16'd221;
    in_val = 1'b1;
    t = 0;
    while (!in_rdy && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    @(negedge clk);
    in_val = 1'b0;
    t = 0;
    while (!div_resp_rdy && t < 100) begin @(negedge clk); t++; end
    chk("reached_wait", int'(div_resp_rdy), 1);
    reset = 1'b0;
    #1;
    chk("midrst_in_rdy", int'(in_rdy), 0);
    chk("midrst_req_val", int'(div_req_val), 0);
    chk("midrst_resp_rdy", int'(div_resp_rdy), 0);
    chk("midrst_out_val", int'(out_val), 0);
    chk("midrst_is_prime", int'(is_prime), 0);
    chk("midrst_factor", int'(factor), 0);
    @(negedge clk);
    reset    = 1'b1;
    hold_rsp = 1'b0;
    #1;
    chk("midrst_release_in_rdy", int'(in_rdy), 1);
    run_cand(16'd221, 0, p, f, reqs, lat, held_bad);
    chk("n221_is_prime", int'(p), 0);
    chk("n221_factor", int'(f), 13);
    chk("n221_requests", reqs, pick(12, 7));
    chk("final_protocol", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aidan_mcnay_prime_seq.md
# aidan_mcnay_prime_seq

Trial-division sequencer that decides whether an unsigned `nbits`-wide candidate is prime. It is the requester for the team's remainder-producing divider: it drives the divider's operand/valid/ready input stream and consumes its result stream, one trial divisor at a time. It sits between the top-level candidate stream and one divider instance, and returns a prime/not-prime verdict with the smallest factor found.

## Interface
- `nbits`, 16, width of candidate, divisor and remainder
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low (0 = in reset)
- `in_num`  input  nbits  candidate n
- `in_val`  input  1  candidate valid
- `in_rdy`  output  1  sequencer can accept a candidate
- `div_opa`  output  nbits  dividend to divider (always n)
- `div_opb`  output  nbits  trial divisor d
- `div_req_val`  output  1  divider request valid
- `div_req_rdy`  input  1  divider accepts request
- `div_result`  input  nbits  remainder n mod d
- `div_resp_val`  input  1  remainder valid
- `div_resp_rdy`  output  1  sequencer accepts remainder
- `is_prime`  output  1  verdict
- `factor`  output  nbits  smallest divisor found; 0 if prime or n<2
- `out_val`  output  1  verdict valid
- `out_rdy`  input  1  consumer accepts verdict

## Operation
- Registers: `n_reg` (nbits), `d_reg` (nbits), `is_prime_reg`, `factor_reg`, 3-bit state.
- States: IDLE, CHECK, REQ, WAIT, DONE.
- IDLE: `in_rdy`=1. On `in_val`: latch n, d←2. If n<2 → `is_prime_reg`=0, `factor_reg`=0, go DONE; else go CHECK.
- CHECK: compute d*d at 2*nbits width (no overflow). If d*d > n → `is_prime_reg`=1, `factor_reg`=0, go DONE; else go REQ.
- REQ: `div_req_val`=1, `div_opa`=n, `div_opb`=d; held stable until `div_req_rdy`; then go WAIT.
- WAIT: `div_resp_rdy`=1. On `div_resp_val`: if `div_result`==0 → `is_prime_reg`=0, `factor_reg`=d, go DONE; else d←next(d), go CHECK.
- next(d): see Configuration.
- DONE: `out_val`=1, `is_prime`/`factor` driven from registers, stable until `out_rdy`; then go IDLE.
- `div_opa`/`div_opb` driven from registers in all states; only meaningful when `div_req_val`=1.
- At most one outstanding divider request; never asserts `div_req_val` while waiting for a response.
- Unused state encodings go to IDLE.

## Timing
- Reset (async, `reset`=0): state IDLE, all registers 0; outputs `in_rdy`=1 after deassertion, `div_req_val`=0, `div_resp_rdy`=0, `out_val`=0, `is_prime`=0, `factor`=0. Reset mid-operation abandons the candidate; the divider shares the reset, so no stale response is expected.
- Candidate accepted on edge with `in_val`&&`in_rdy`; CHECK occupies the next cycle; `div_req_val` rises one cycle after CHECK.
- n<2: `out_val` one cycle after acceptance. n=2 or 3: `out_val` two cycles after acceptance (single CHECK, no divider traffic).
- Each trial costs 1 CHECK cycle + ≥1 REQ cycle + ≥1 WAIT cycle + divider latency.
- Response and request handshakes complete on the same edge only as described; `div_resp_val` arriving outside WAIT is ignored (protocol error, not expected).
- Back-to-back: `in_rdy` is 1 the cycle after the DONE handshake; no overlap between candidates.
- `out_val` with `out_rdy`=0 stalls indefinitely with outputs held.

## Configuration
- `PRIME_SEQ_ODD_ONLY_EN` defined: next(2)=3, next(d)=d+2 for d≥3 (even divisors skipped).
- Undefined: next(d)=d+1.
- Verdict and `factor` identical in both builds; only the number of divider requests differs.

## Test plan
- Reset with `in_val`=1 held: while `reset`=0 → `in_rdy`, `out_val`, `div_req_val` all 0; no request issued until release.
- n=0, 1, 2, 3 → `is_prime`=0,0,1,1, `factor`=0, zero divider requests.
- n=9 → requests d=2 (rem 1), d=3 (rem 0); `is_prime`=0, `factor`=3.
- n=49 → odd-only build: 4 requests (2,3,5,7); default build: 6 requests (2..7); both `is_prime`=0, `factor`=7.
- n=65521 with random `div_req_rdy`/`div_resp_val` delays and `out_rdy` held low 5 cycles → `is_prime`=1, `factor`=0; 128 requests (odd-only) or 254 (default); `div_opb` stable while `div_req_val`&&!`div_req_rdy`; outputs held during stall.
- Reset asserted while in WAIT for n=221 → immediate IDLE, outputs at reset values; next candidate 221 → `is_prime`=0, `factor`=13.
